// File: rtl/iterative_math_pkg.sv
// Shared mode encoding and FSM state type for the iterative arithmetic accelerator.
package iterative_math_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_FACT = 2'd0;
  localparam logic [MODE_W-1:0] MODE_POW  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SUM  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_math_step.sv
// Combinational single iteration step: next acc/cnt, step overflow and finish detect.
module iterative_math_step
  import iterative_math_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_acc,
  input  logic [WIDTH-1:0]  i_cnt,
  input  logic [WIDTH-1:0]  i_base,
  output logic [WIDTH-1:0]  o_acc,
  output logic [WIDTH-1:0]  o_cnt,
  output logic              o_ovf,
  output logic              o_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]   w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_sum;

  // Power multiplies by the latched base, factorial by the running counter.
  assign w_mul_b = (i_mode == MODE_POW) ? i_base : i_cnt;
  assign w_prod  = {{WIDTH{1'b0}}, i_acc} * {{WIDTH{1'b0}}, w_mul_b};
  assign w_sum   = {1'b0, i_acc} + {1'b0, i_cnt};

  always_comb begin
    o_acc  = i_acc;
    o_cnt  = i_cnt;
    o_ovf  = 1'b0;
    o_done = 1'b1;
    case (i_mode)
      MODE_FACT: begin
        if (i_cnt > ONE) begin
          o_acc  = w_prod[WIDTH-1:0];
          o_cnt  = i_cnt - ONE;
          o_ovf  = |w_prod[2*WIDTH-1:WIDTH];
          o_done = 1'b0;
        end
      end
      MODE_POW: begin
        if (i_cnt != '0) begin
          o_acc  = w_prod[WIDTH-1:0];
          o_cnt  = i_cnt - ONE;
          o_ovf  = |w_prod[2*WIDTH-1:WIDTH];
          o_done = 1'b0;
        end
      end
      MODE_SUM: begin
        if (i_cnt != '0) begin
          o_acc  = w_sum[WIDTH-1:0];
          o_cnt  = i_cnt - ONE;
          o_ovf  = w_sum[WIDTH];
          o_done = 1'b0;
        end
      end
      default: begin
        o_done = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/iterative_math_mmio.sv
// Multi-mode iterative accelerator (factorial, power, triangular sum) with abort and sticky overflow.
// Build option: ITERMATH_SATURATE_EN ends an operation at its first overflowing step with an all-ones result.
module iterative_math_mmio #(
  parameter int WIDTH  = 32,
  parameter int MODE_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              abort,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [WIDTH-1:0]  result,
  output logic              overflow,
  output logic              err,
  output logic              busy
);

  import iterative_math_pkg::*;

  state_e            r_state;
  logic [MODE_W-1:0] r_mode;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_base;
  logic              r_ovf_flag;
  logic [WIDTH-1:0]  r_result;
  logic              r_overflow;
  logic              r_err;

  logic [WIDTH-1:0]  w_acc_nxt;
  logic [WIDTH-1:0]  w_cnt_nxt;
  logic              w_step_ovf;
  logic              w_done;

  iterative_math_step #(.WIDTH(WIDTH)) u_step (
    .i_mode (r_mode),
    .i_acc  (r_acc),
    .i_cnt  (r_cnt),
    .i_base (r_base),
    .o_acc  (w_acc_nxt),
    .o_cnt  (w_cnt_nxt),
    .o_ovf  (w_step_ovf),
    .o_done (w_done)
  );

  // Handshakes: a request transfers on a rising edge where input_valid && input_ready;
  // a result transfers on a rising edge where output_valid && output_ready. Both readies
  // and valids are pure decodes of the state register, so nothing turns around in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_base     <= '0;
      r_ovf_flag <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (input_valid) begin
            r_mode     <= mode;
            r_base     <= x;
            r_ovf_flag <= 1'b0;
            r_state    <= S_RUN;
            case (mode)
              MODE_FACT: begin
                r_acc <= WIDTH'(1);
                r_cnt <= x;
              end
              MODE_POW: begin
                r_acc <= WIDTH'(1);
                r_cnt <= y;
              end
              MODE_SUM: begin
                r_acc <= '0;
                r_cnt <= x;
              end
              default: begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_result   <= '0;
                r_overflow <= 1'b0;
                r_err      <= 1'b1;
                r_state    <= S_DONE;
              end
            endcase
          end
        end
        S_RUN: begin
          // Abort outranks a finish landing on the same edge.
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_done) begin
            r_result   <= r_acc;
            r_overflow <= r_ovf_flag;
            r_err      <= 1'b0;
            r_state    <= S_DONE;
`ifdef ITERMATH_SATURATE_EN
          end else if (w_step_ovf) begin
            r_result   <= '1;
            r_overflow <= 1'b1;
            r_err      <= 1'b0;
            r_state    <= S_DONE;
`endif
          end else begin
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_flag <= r_ovf_flag | w_step_ovf;
          end
        end
        S_DONE: begin
          if (abort || output_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign input_ready  = (r_state == S_IDLE);
  assign output_valid = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign overflow     = r_overflow;
  assign err          = r_err;

endmodule

// File: tb/tb_iterative_math_mmio.sv
// Self-checking bench for iterative_math_mmio: directed spec vectors, abort/reset cases and randomized ops.
module tb_iterative_math_mmio;

  localparam int WIDTH = 32;

  logic              clock;
  logic              reset_n;
  logic              input_valid;
  logic              input_ready;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              abort;
  logic              output_valid;
  logic              output_ready;
  logic [WIDTH-1:0]  result;
  logic              overflow;
  logic              err;
  logic              busy;

  int n_checks;
  int n_errors;

  iterative_math_mmio #(.WIDTH(WIDTH), .MODE_W(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .mode         (mode),
    .x            (x),
    .y            (y),
    .abort        (abort),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .result       (result),
    .overflow     (overflow),
    .err          (err),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: value, true overflow, and edges from the accepting edge to output_valid.
  function automatic void model(input logic [1:0] m, input logic [31:0] xx, input logic [31:0] yy,
                                output logic [31:0] r, output bit o, output bit e, output int lat);
    longint unsigned w, tv, f, n_steps;
    longint unsigned cap_v;
    longint unsigned lim;
    int s;
    cap_v = 64'h2_0000_0000;
    lim   = 64'hFFFF_FFFF;
    o = 1'b0;
    e = 1'b0;
    s = 0;
    if (m == 2'd3) begin
      r = '0;
      e = 1'b1;
      lat = 0;
      return;
    end
    w = (m == 2'd2) ? 0 : 1;
    tv = w;
    if (m == 2'd0) n_steps = (xx > 1) ? longint'(xx) - 1 : 0;
    else if (m == 2'd1) n_steps = yy;
    else n_steps = xx;
    for (longint unsigned k = 0; k < n_steps; k++) begin
      if (m == 2'd1) f = xx;
      else f = longint'(xx) - k;
      if (m == 2'd2) begin
        w  = (w + f) & lim;
        tv = (tv + f > cap_v) ? cap_v : tv + f;
      end else begin
        w  = (w * f) & lim;
        tv = (f != 0 && tv > cap_v / f) ? cap_v : tv * f;
      end
      s++;
      if (tv > lim && !o) begin
        o = 1'b1;
`ifdef ITERMATH_SATURATE_EN
        r = 32'hFFFF_FFFF;
        lat = s;
        return;
`endif
      end
    end
    r = w[31:0];
    lat = s + 1;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!input_ready && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    n_checks++;
    if (!input_ready) begin
      n_errors++;
      $display("FAIL %s idle_timeout: input_ready=%0b required 1", name, input_ready);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input logic [31:0] xx,
                        input logic [31:0] yy, input int hold);
    logic [31:0] er;
    bit eo, ee;
    int el, lat;
    model(m, xx, yy, er, eo, ee, el);
    wait_idle(name);
    @(negedge clock);
    input_valid = 1'b1;
    mode = m;
    x = xx;
    y = yy;
    @(posedge clock); #1;
    input_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    mode = 2'($urandom_range(0, 3));
    lat = 0;
    while (!output_valid && lat < 3000) begin
      @(posedge clock); #1;
      lat++;
    end
    n_checks++;
    if (!output_valid) begin
      n_errors++;
      $display("FAIL %s valid_timeout: output_valid=0 required 1", name);
    end
    n_checks++;
    if (lat !== el) begin
      n_errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, el);
    end
    n_checks++;
    if (result !== er || overflow !== eo || err !== ee) begin
      n_errors++;
      $display("FAIL %s result: got %0d/ovf=%0b/err=%0b required %0d/ovf=%0b/err=%0b",
               name, result, overflow, err, er, eo, ee);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (output_valid !== 1'b1 || result !== er) begin
        n_errors++;
        $display("FAIL %s hold%0d: valid=%0b result=%0d required valid=1 result=%0d",
                 name, i, output_valid, result, er);
      end
    end
    @(negedge clock);
    output_ready = 1'b1;
    @(posedge clock); #1;
    output_ready = 1'b0;
    n_checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1 || result !== er) begin
      n_errors++;
      $display("FAIL %s handshake: valid=%0b ready=%0b result=%0d required 0/1/%0d",
               name, output_valid, input_ready, result, er);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({input_ready, output_valid, busy, overflow, err} !== 5'b10000 || result !== '0) begin
      n_errors++;
      $display("FAIL reset: rdy/val/busy/ovf/err=%b result=%0d required 10000 result=0",
               {input_ready, output_valid, busy, overflow, err}, result);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (input_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset: ready=%0b busy=%0b required 1/0", input_ready, busy);
    end
  endtask

  task automatic test_directed();
    run_op("fact5", 2'd0, 32'd5, 32'd0, 3);
    run_op("fact13", 2'd0, 32'd13, 32'd0, 0);
    run_op("fact12", 2'd0, 32'd12, 32'd0, 0);
    run_op("fact0", 2'd0, 32'd0, 32'd0, 0);
    run_op("fact1", 2'd0, 32'd1, 32'd0, 0);
    run_op("pow3_5", 2'd1, 32'd3, 32'd5, 0);
    run_op("pow2_32", 2'd1, 32'd2, 32'd32, 0);
    run_op("pow0_0", 2'd1, 32'd0, 32'd0, 0);
    run_op("sum100", 2'd2, 32'd100, 32'd0, 0);
    run_op("sum0", 2'd2, 32'd0, 32'd0, 0);
    run_op("rsvd", 2'd3, 32'd7, 32'd9, 1);
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [31:0] xx, yy;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 3));
      case (m)
        2'd0: begin xx = $urandom_range(0, 16); yy = $urandom; end
        2'd1: begin xx = $urandom_range(0, 40); yy = $urandom_range(0, 14); end
        2'd2: begin xx = $urandom_range(0, 300); yy = $urandom; end
        default: begin xx = $urandom; yy = $urandom; end
      endcase
      run_op($sformatf("rand%0d", i), m, xx, yy, $urandom_range(0, 2));
    end
  endtask

  task automatic test_abort_run();
    bit seen;
    run_op("abort_pre", 2'd0, 32'd3, 32'd0, 0);
    @(negedge clock);
    input_valid = 1'b1;
    mode = 2'd0;
    x = 32'd10;
    @(posedge clock); #1;
    input_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    n_checks++;
    if (input_ready !== 1'b1 || busy !== 1'b0 || output_valid !== 1'b0 || result !== 32'd6) begin
      n_errors++;
      $display("FAIL abort_run: ready=%0b busy=%0b valid=%0b result=%0d required 1/0/0/6",
               input_ready, busy, output_valid, result);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      seen |= output_valid;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL abort_no_valid: output_valid seen=1 required 0");
    end
  endtask

  task automatic test_abort_done();
    int n;
    wait_idle("abort_done");
    @(negedge clock);
    input_valid = 1'b1;
    mode = 2'd0;
    x = 32'd2;
    @(posedge clock); #1;
    input_valid = 1'b0;
    n = 0;
    while (!output_valid && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    @(negedge clock);
    abort = 1'b1;
    output_ready = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    output_ready = 1'b0;
    n_checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_done: valid=%0b ready=%0b required 0/1", output_valid, input_ready);
    end
    run_op("after_abort", 2'd2, 32'd10, 32'd0, 0);
  endtask

  task automatic test_reset_mid_run();
    wait_idle("rst_mid");
    @(negedge clock);
    input_valid = 1'b1;
    mode = 2'd0;
    x = 32'd8;
    @(posedge clock); #1;
    input_valid = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({input_ready, output_valid, busy, overflow, err} !== 5'b10000 || result !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_run: rdy/val/busy/ovf/err=%b result=%0d required 10000 result=0",
               {input_ready, output_valid, busy, overflow, err}, result);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_op("fact4_after_rst", 2'd0, 32'd4, 32'd0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    bit eo, ee;
    int el, n;
    model(2'd0, 32'd3, 32'd0, er, eo, ee, el);
    wait_idle("b2b");
    @(negedge clock);
    input_valid = 1'b1;
    mode = 2'd0;
    x = 32'd3;
    output_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!output_valid && n < 100) begin
        @(posedge clock); #1;
        n++;
      end
      n_checks++;
      if (output_valid !== 1'b1 || result !== er) begin
        n_errors++;
        $display("FAIL b2b%0d result: valid=%0b result=%0d required 1/%0d", k, output_valid, result, er);
      end
      @(posedge clock); #1;
      n_checks++;
      if (input_ready !== 1'b1 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b%0d idle: ready=%0b busy=%0b required 1/0", k, input_ready, busy);
      end
      @(posedge clock); #1;
      n_checks++;
      if (input_ready !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b%0d accept: ready=%0b busy=%0b required 0/1", k, input_ready, busy);
      end
    end
    @(negedge clock);
    input_valid = 1'b0;
    wait_idle("b2b_drain");
    output_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    input_valid = 1'b0;
    mode = 2'd0;
    x = '0;
    y = '0;
    abort = 1'b0;
    output_ready = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_directed();
    test_abort_run();
    test_abort_done();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
